// File: rtl/sample_gate.sv
// sample_gate: registered 3-input / 2-output truth-table evaluator.
//
// Samples A, B and C and produces two registered Boolean functions D and E.
// Each function is an 8-entry truth table indexed by {A,B,C}, with A as the MSB.
// The defaults turn the cell into a pipelined full adder:
//   D = A^B^C (sum), E = majority(A,B,C) (carry), C = carry-in.
//
// Parameters:
//   LUT_D     truth table for D (default 8'h96, odd parity)
//   LUT_E     truth table for E (default 8'hE8, majority)
//   INPUT_REG 1 = input register ahead of evaluation (latency 2)
//             0 = evaluate the live inputs (latency 1)
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset; clears the input stage and D/E
//   A,B,C  operand bits; they form the truth-table index {A,B,C}
//   D      registered LUT_D[{A,B,C}]
//   E      registered LUT_E[{A,B,C}]

module sample_gate #(
  parameter logic [7:0] LUT_D     = 8'h96,
  parameter logic [7:0] LUT_E     = 8'hE8,
  parameter bit         INPUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic D,
  output logic E
);

  logic [2:0] eval_idx;

  if (INPUT_REG) begin : g_in_reg
    logic [2:0] idx_q;

    // Reset clears the index to 3'b000. The first output after release is
    // therefore LUT[0], and no sample from before reset can reach D/E.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        idx_q <= 3'b000;
      end else begin
        idx_q <= {A, B, C};
      end
    end

    assign eval_idx = idx_q;
  end else begin : g_no_in_reg
    assign eval_idx = {A, B, C};
  end

  // During reset the outputs are forced to zero. They are not loaded from
  // LUT[0], so a table with LUT[0]=1 still reads 0 while rst_n is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      D <= 1'b0;
      E <= 1'b0;
    end else begin
      D <= LUT_D[eval_idx];
      E <= LUT_E[eval_idx];
    end
  end

endmodule

// File: tb/tb_sample_gate.sv
// Testbench for sample_gate. Three instances share the same stimulus:
//   dut 0: defaults (full adder, INPUT_REG=1)
//   dut 1: full adder with INPUT_REG=0
//   dut 2: LUT_D=8'h01, LUT_E=8'h80, INPUT_REG=1
// The stimulus pushes the values each instance should show after the next
// edge. The monitor pops those values and compares them one edge later.

module tb_sample_gate;

  logic clk;
  logic rst_n;
  logic a, b, c;
  logic d0, e0, d1, e1, d2, e2;

  sample_gate u_def (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d0), .E(e0)
  );

  sample_gate #(.INPUT_REG(1'b0)) u_noreg (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d1), .E(e1)
  );

  sample_gate #(.LUT_D(8'h01), .LUT_E(8'h80), .INPUT_REG(1'b1)) u_cust (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d2), .E(e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written truth tables, indexed by code {A,B,C}.
  // Full adder:  000 001 010 011 100 101 110 111
  //   sum        0   1   1   0   1   0   0   1
  //   carry      0   0   0   1   0   1   1   1
  // Custom: D is 1 only for 000, E is 1 only for 111.
  logic fa_sum [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic fa_cy  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic cu_d   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic cu_e   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct {
    int    cyc;
    int    dut;
    logic  d;
    logic  e;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // Index held by the input register of the pipelined instances.
  logic [2:0] prev_idx = 3'b000;

  task automatic push(input int cy, input int dut, input logic dv, input logic ev,
                      input string tag);
    exp_t x;
    x.cyc = cy;
    x.dut = dut;
    x.d   = dv;
    x.e   = ev;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Drive one vector at the falling edge. Queue what each instance should
  // present after the next rising edge.
  task automatic drive(input logic [2:0] code, input logic rst, input string tag);
    @(negedge clk);
    {a, b, c} = code;
    rst_n = rst;
    push(cyc + 1, 0, rst ? fa_sum[prev_idx] : 1'b0, rst ? fa_cy[prev_idx] : 1'b0, tag);
    push(cyc + 1, 1, rst ? fa_sum[code]     : 1'b0, rst ? fa_cy[code]     : 1'b0, tag);
    push(cyc + 1, 2, rst ? cu_d[prev_idx]   : 1'b0, rst ? cu_e[prev_idx]   : 1'b0, tag);
    prev_idx = rst ? code : 3'b000;
  endtask

  // Monitor: check every expectation queued for this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        exp_t x;
        logic ad, ae;
        x = exp_q.pop_front();
        case (x.dut)
          0:       begin ad = d0; ae = e0; end
          1:       begin ad = d1; ae = e1; end
          default: begin ad = d2; ae = e2; end
        endcase
        tests = tests + 1;
        if (x.cyc != cyc) begin
          fails = fails + 1;
          $display("FAIL %s dut%0d: expectation for cycle %0d checked at cycle %0d",
                   x.tag, x.dut, x.cyc, cyc);
        end else if (ad !== x.d || ae !== x.e) begin
          fails = fails + 1;
          $display("FAIL %s dut%0d cyc %0d: got D=%b E=%b, expected D=%b E=%b",
                   x.tag, x.dut, cyc, ad, ae, x.d, x.e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {a, b, c} = 3'b111;

    // Reset with all inputs at 1; the outputs must stay 0.
    for (int i = 0; i < 3; i++) drive(3'b111, 1'b0, "reset_hold");
    // Release. The first edge gives LUT[0]; the second gives the 111 result.
    drive(3'b111, 1'b1, "reset_release");
    drive(3'b111, 1'b1, "reset_release");

    // Directed sweep with 10-cycle holds.
    for (int code = 0; code < 4; code++)
      for (int i = 0; i < 10; i++) drive(3'(code), 1'b1, "sweep");

    // Exhaustive stream with back-to-back codes.
    for (int code = 0; code < 8; code++) drive(3'(code), 1'b1, "stream");
    for (int code = 7; code >= 0; code--) drive(3'(code), 1'b1, "stream_rev");

    // Reset in mid-stream: the 101 result must never appear.
    drive(3'b111, 1'b1, "mid_stream");
    drive(3'b110, 1'b1, "mid_stream");
    drive(3'b101, 1'b1, "mid_stream");
    drive(3'b101, 1'b0, "mid_reset");
    drive(3'b101, 1'b1, "post_reset");
    drive(3'b101, 1'b1, "post_reset");

    // Single 011 check for the unregistered build, plus the custom table.
    drive(3'b011, 1'b1, "code011");
    drive(3'b000, 1'b1, "custom");
    drive(3'b111, 1'b1, "custom");
    drive(3'b010, 1'b1, "custom");
    drive(3'b000, 1'b1, "flush");
    drive(3'b000, 1'b1, "flush");

    @(negedge clk);
    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_gate.md
Name: sample_gate

Overview:
- Small registered 3-input/2-output logic evaluator.
- Samples inputs A, B, C every clock and produces two registered Boolean functions, D and E, each defined by an 8-entry truth-table parameter.
- Defaults make the block a pipelined full adder: D = sum, E = carry, with C as carry-in.
- Used as a leaf glue-logic cell wherever a clean, registered, reset-defined 3-to-2 function is needed.

Parameters:
- LUT_D, 8'h96, truth table for D; bit index = {A,B,C} with A as MSB. Default is odd parity A^B^C.
- LUT_E, 8'hE8, truth table for E with the same indexing. Default is majority, (A&B)|(A&C)|(B&C).
- INPUT_REG, 1, 1 = register inputs before evaluation (latency 2); 0 = evaluate inputs directly (latency 1).

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst_n  input  1  Reset, synchronous and active-low. Sampled on the rising edge of clk.
- A  input  1  Operand bit; MSB of the truth-table index.
- B  input  1  Operand bit; middle bit of the index.
- C  input  1  Operand bit / carry-in; LSB of the index.
- D  output  1  Registered LUT_D[{A,B,C}].
- E  output  1  Registered LUT_E[{A,B,C}].

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. There is no asynchronous reset path.
- Reset: a rising edge of clk with rst_n=0 clears the input-stage register to 3'b000 and sets D=0 and E=0.
  - These values are forced regardless of the LUT contents. D/E are not set to LUT[0].
  - D and E stay 0 on every edge that rst_n is low.
- INPUT_REG=1:
  - Edge n captures idx={A,B,C}.
  - Edge n+1 loads D=LUT_D[idx] and E=LUT_E[idx].
  - Outputs therefore reflect inputs two edges after they are applied.
  - Throughput is one new evaluation per cycle; fully pipelined with no bubbles.
- INPUT_REG=0: edge n loads D/E directly from the inputs present at edge n (latency 1).
- Outputs D and E come straight from flops. There is no combinational path from any input to D or E.
- Reset release (first edge with rst_n=1):
  - The pipeline starts from the cleared input register.
  - With INPUT_REG=1, the first output edge after release presents LUT_D[0] and LUT_E[0] (0,0 for the defaults).
  - Valid results appear from the second edge after release.
- Reset mid-operation: takes effect on the next clock edge and discards all in-flight samples. No result computed before reset appears after it.
- Inputs held constant: outputs remain constant, with no glitching or toggling.
- X/Z inputs are not supported; drivers must present clean 0/1 levels.
- Default function (full adder), as {A,B,C} -> D,E:
  - 000->0,0
  - 001->1,0
  - 010->1,0
  - 011->0,1
  - 100->1,0
  - 101->0,1
  - 110->0,1
  - 111->1,1

Test Plan:
- Reset check: hold rst_n=0 for 3 edges with A=B=C=1 -> D=0 and E=0 on every edge. Release, then after 2 edges -> D=1, E=1.
- Directed sweep (defaults, INPUT_REG=1): apply {A,B,C}=000, 001, 010, 011, one per 10-cycle hold. Two edges after each change, D,E must be 0,0 / 1,0 / 1,0 / 0,1.
- Exhaustive back-to-back: drive all 8 codes on consecutive cycles -> D,E stream matches the default table with exactly 2-cycle lag and no bubbles.
- Mid-stream reset: stream codes 111, 110, 101; assert rst_n=0 for 1 edge on the cycle after 101 is applied. D,E must be 0,0 on that edge and on the next edge; the 101 result never appears.
- INPUT_REG=0 build: apply 011 -> D=0, E=1 on the very next edge.
- Custom LUT: set LUT_D=8'h01 and LUT_E=8'h80. Code 000 -> D=1, E=0; code 111 -> D=0, E=1; all other codes -> 0,0.
